// File: rtl/mda_vram_arbiter_pkg.sv
// Shared constants and owner tag for the MDA video RAM arbiter.
// No ports: geometry, VRAM sizing and the RAM-cycle owner enum.
package mda_pkg;

    localparam int COLS       = 80;
    localparam int ROWS       = 25;
    localparam int CHAR_W     = 9;
    localparam int FETCH_SLOT = 5;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 16;
    localparam int VRAM_DEPTH = COLS * ROWS;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_HOST
    } owner_e;

endpackage

// File: rtl/mda_vram_arbiter_if.sv
// Host read/write port of the VRAM arbiter as a req/ack bundle.
// Ports: host_req/we/addr/wdata (host -> arbiter), host_ack/rdata (back).
interface mda_vram_arbiter_if;
    import mda_pkg::*;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata
    );

endinterface

// File: rtl/mda_vram_arbiter_cell_addr.sv
// Cell word address: row*COLS + col + inc, row*80 built as (row<<6)+(row<<4).
// Ports: row, col, inc in; addr out (ADDR_W bits, max 1999 so no wrap).
module mda_cell_addr
    import mda_pkg::*;
(
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row_x64;
    logic [ADDR_W-1:0] row_x16;

    always_comb begin
        row_x64 = {row, 6'b0};
        row_x16 = {2'b0, row, 4'b0};
        addr    = row_x64 + row_x16 + {4'b0, col} + {10'b0, inc};
    end

endmodule

// File: rtl/mda_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch slot first, host gets spare cycles.
// Ports: clk/rst, position inputs, host bundle, RAM port, disp_char/attr.
module mda_vram_arbiter
    import mda_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [6:0]        col,
    input  logic [4:0]        row,
    input  logic [3:0]        char_pixel,
    input  logic              add_one,
    mda_vram_arbiter_if.slave host,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        disp_char,
    output logic [7:0]        disp_attr
);

    owner_e            owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              rd_ok_q, rd_ok_d;
    logic              blank_q, blank_d;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] stage_q, stage_d;
    logic [7:0]        disp_char_q, disp_char_d;
    logic [7:0]        disp_attr_q, disp_attr_d;

    logic              act_slot;
    logic              blank_slot;
    logic              disp_slot;
    logic              host_issue;
    logic              in_range;
    logic [ADDR_W-1:0] cell_addr;

    // Blank fetch ignores add_one so it lands on the first cell of the line.
    mda_cell_addr u_cell_addr (
        .row  (row),
        .col  (col),
        .inc  (enable & add_one),
        .addr (cell_addr)
    );

    always_comb begin
        act_slot   = enable && (char_pixel == 4'(FETCH_SLOT));
        blank_slot = !enable && !blank_q;
        // No RAM traffic while reset is held so the RAM port reads as idle.
        disp_slot  = !rst && (act_slot || blank_slot);
        host_issue = !rst && host.host_req && !busy_q && !disp_slot;
        in_range   = host.host_addr < ADDR_W'(VRAM_DEPTH);
    end

    always_comb begin
        ram_addr    = ram_addr_q;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        owner_d     = OWN_NONE;
        busy_d      = 1'b0;
        rd_ok_d     = 1'b0;
        blank_d     = !enable && (blank_q || disp_slot);
        stage_d     = stage_q;
        disp_char_d = disp_char_q;
        disp_attr_d = disp_attr_q;

        if (disp_slot) begin
            ram_addr = cell_addr;
            owner_d  = OWN_DISP;
        end else if (host_issue) begin
            ram_addr  = host.host_addr;
            ram_we    = host.host_we && in_range;
            ram_wdata = host.host_wdata;
            owner_d   = OWN_HOST;
            busy_d    = 1'b1;
            rd_ok_d   = !host.host_we && in_range;
        end

        if (owner_q == OWN_DISP) begin
            stage_d = ram_rdata;
        end

        if (enable && (char_pixel == 4'(CHAR_W - 1))) begin
            disp_char_d = stage_q[7:0];
            disp_attr_d = stage_q[15:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            busy_q      <= 1'b0;
            rd_ok_q     <= 1'b0;
            blank_q     <= 1'b0;
            ram_addr_q  <= '0;
            stage_q     <= '0;
            disp_char_q <= '0;
            disp_attr_q <= '0;
        end else begin
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            rd_ok_q     <= rd_ok_d;
            blank_q     <= blank_d;
            ram_addr_q  <= ram_addr;
            stage_q     <= stage_d;
            disp_char_q <= disp_char_d;
            disp_attr_q <= disp_attr_d;
        end
    end

    // Read data arrives the cycle after issue, which is the ack cycle.
    always_comb begin
        host.host_ack   = busy_q;
        host.host_rdata = (busy_q && rd_ok_q) ? ram_rdata : '0;
        disp_char       = disp_char_q;
        disp_attr       = disp_attr_q;
    end

endmodule

// File: tb/tb_mda_vram_arbiter.sv
// Directed bench for mda_vram_arbiter with a behavioural sync RAM.
// Drives position/host inputs, checks RAM port, host acks and cell output.
module tb_mda_vram_arbiter;
    import mda_pkg::*;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [6:0]        col;
    logic [4:0]        row;
    logic [3:0]        char_pixel;
    logic              add_one;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [7:0]        disp_char;
    logic [7:0]        disp_attr;

    logic [15:0] mem [0:2047];
    logic        loaded = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    mda_vram_arbiter_if hif ();

    mda_vram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .col        (col),
        .row        (row),
        .char_pixel (char_pixel),
        .add_one    (add_one),
        .host       (hif.slave),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .disp_char  (disp_char),
        .disp_attr  (disp_attr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 257) ^ 16'h5A3C;
    endfunction

    // Synchronous single-port RAM, read-before-write, preset on first edge.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
            mem[81]   <= 16'h0741;
            mem[2000] <= 16'hDEAD;
            mem[2047] <= 16'hBEEF;
            loaded    <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock; position counter advances only while enable is high.
    task automatic tick();
        @(posedge clk);
        #1;
        if (enable) begin
            if (char_pixel == 4'(CHAR_W - 1)) begin
                char_pixel = 4'd0;
                if (col == 7'(COLS - 1)) begin
                    col = 7'd0;
                    row = row + 5'd1;
                end else begin
                    col = col + 7'd1;
                end
            end else begin
                char_pixel = char_pixel + 4'd1;
            end
        end
    endtask

    task automatic host_set(input logic req, input logic we,
                            input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        hif.host_req   = req;
        hif.host_we    = we;
        hif.host_addr  = a;
        hif.host_wdata = d;
    endtask

    initial begin
        int last;
        int nacks;
        int acks;
        int c;
        logic pend;
        logic drop;
        logic [ADDR_W-1:0] haddr;

        rst        = 1'b1;
        enable     = 1'b0;
        col        = '0;
        row        = '0;
        char_pixel = '0;
        add_one    = 1'b0;
        host_set(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        #2;
        chk("rst_ack",   32'(hif.host_ack),   0);
        chk("rst_rdata", 32'(hif.host_rdata), 0);
        chk("rst_we",    32'(ram_we),         0);
        chk("rst_addr",  32'(ram_addr),       0);
        chk("rst_wdata", 32'(ram_wdata),      0);
        chk("rst_char",  32'(disp_char),      0);
        chk("rst_attr",  32'(disp_attr),      0);

        // Release: one blank prefetch of word 0, then host gets the RAM.
        tick();
        rst = 1'b0;
        #2;
        chk("blank_addr", 32'(ram_addr), 0);
        chk("blank_we",   32'(ram_we),   0);
        tick();
        host_set(1'b1, 1'b0, 11'd3, '0);
        #2;
        chk("blank_once_issue", 32'(ram_addr), 3);
        tick();
        #2;
        chk("rd3_ack",   32'(hif.host_ack),   1);
        chk("rd3_rdata", 32'(hif.host_rdata), 32'(init_word(3)));
        tick();
        host_set(1'b0, 1'b0, '0, '0);

        // Active fetch with add_one: row 1 col 0 fetches word 81.
        enable  = 1'b1;
        row     = 5'd1;
        col     = 7'd0;
        add_one = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #2;
        chk("fetch_addr", 32'(ram_addr), 81);
        chk("fetch_we",   32'(ram_we),   0);
        for (int i = 0; i < 4; i++) tick();
        #2;
        chk("disp_char81", 32'(disp_char), 32'h41);
        chk("disp_attr81", 32'(disp_attr), 32'h07);

        // Host write on the fetch slot is deferred one cycle.
        for (int i = 0; i < 5; i++) tick();
        host_set(1'b1, 1'b1, 11'd10, 16'hABCD);
        #2;
        chk("wr_slot_addr", 32'(ram_addr), 82);
        chk("wr_slot_we",   32'(ram_we),   0);
        tick();
        #2;
        chk("wr_cp",    32'(char_pixel),   6);
        chk("wr_we",    32'(ram_we),       1);
        chk("wr_addr",  32'(ram_addr),     10);
        chk("wr_wdata", 32'(ram_wdata),    32'hABCD);
        chk("wr_noack", 32'(hif.host_ack), 0);
        tick();
        #2;
        chk("wr_ack",   32'(hif.host_ack),   1);
        chk("wr_rdata", 32'(hif.host_rdata), 0);
        chk("wr_ack_noissue", 32'(ram_we),   0);
        tick();
        host_set(1'b1, 1'b0, 11'd10, '0);
        #2;
        chk("rd10_addr", 32'(ram_addr), 10);
        tick();
        #2;
        chk("rd10_ack",   32'(hif.host_ack),   1);
        chk("rd10_rdata", 32'(hif.host_rdata), 32'hABCD);
        tick();
        host_set(1'b0, 1'b0, '0, '0);

        // Blank slot on enable drop ignores add_one.
        enable = 1'b0;
        #2;
        chk("blank2_addr", 32'(ram_addr), 80 + 2);
        tick();

        host_set(1'b1, 1'b0, 11'd2000, '0);
        #2;
        chk("oor_rd_addr", 32'(ram_addr), 2000);
        chk("oor_rd_we",   32'(ram_we),   0);
        tick();
        #2;
        chk("oor_rd_ack",   32'(hif.host_ack),   1);
        chk("oor_rd_rdata", 32'(hif.host_rdata), 0);
        tick();
        host_set(1'b0, 1'b0, '0, '0);
        #2;
        chk("idle_hold_addr", 32'(ram_addr),     2000);
        chk("idle_ack",       32'(hif.host_ack), 0);
        tick();
        host_set(1'b1, 1'b1, 11'd2047, 16'h1234);
        #2;
        chk("oor_wr_we", 32'(ram_we), 0);
        tick();
        #2;
        chk("oor_wr_ack",   32'(hif.host_ack),   1);
        chk("oor_wr_rdata", 32'(hif.host_rdata), 0);
        tick();
        host_set(1'b0, 1'b0, '0, '0);
        #2;
        chk("oor_wr_keep", 32'(mem[2047]), 32'hBEEF);

        // Reset the cycle after issue: ack dropped, request serviced once.
        tick();
        host_set(1'b1, 1'b0, 11'd20, '0);
        #2;
        chk("rr_issue", 32'(ram_addr), 20);
        tick();
        rst = 1'b1;
        #2;
        chk("rr_noack0", 32'(hif.host_ack), 0);
        tick();
        #2;
        chk("rr_noack1", 32'(hif.host_ack), 0);
        tick();
        rst  = 1'b0;
        acks = 0;
        drop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #2;
            if (hif.host_ack) begin
                acks++;
                chk("rr_rdata", 32'(hif.host_rdata), 32'(init_word(20)));
                drop = 1'b1;
            end
            tick();
            if (drop) hif.host_req = 1'b0;
        end
        chk("rr_once", 32'(acks), 1);

        // Full row under continuous host load.
        row        = 5'd2;
        col        = 7'd0;
        char_pixel = 4'd0;
        add_one    = 1'b0;
        enable     = 1'b1;
        haddr      = 11'd300;
        host_set(1'b1, 1'b0, haddr, '0);
        last  = -1;
        nacks = 0;
        pend  = 1'b0;
        for (int n = 0; n < COLS * CHAR_W + 1; n++) begin
            if (pend) begin
                haddr          = haddr + 11'd1;
                hif.host_addr  = haddr;
                pend           = 1'b0;
            end
            #2;
            if (char_pixel == 4'd0 && n > 0) begin
                c = (col == 7'd0) ? COLS - 1 : int'(col) - 1;
                chk("row_char", 32'(disp_char), 32'(mem[160 + c][7:0]));
                chk("row_attr", 32'(disp_attr), 32'(mem[160 + c][15:8]));
            end
            if (hif.host_ack) begin
                chk("row_rdata", 32'(hif.host_rdata), 32'(mem[haddr]));
                if (last >= 0) begin
                    chk("row_gap", 32'((n - last == 2) || (n - last == 3)), 1);
                end
                last = n;
                nacks++;
                pend = 1'b1;
            end
            tick();
        end
        host_set(1'b0, 1'b0, '0, '0);
        chk("row_nacks_min", 32'(nacks >= (COLS * CHAR_W) / 3), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
